// File: rtl/spike_packet_router.sv
// spike_packet_router: buffers send-stage spike packets in a small FIFO and
// routes each one with dimension-ordered XY routing, X first.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   packet_in          packet from the send stage
//   packet_in_valid    qualifies packet_in (no back-pressure upstream)
//   route_packet       head packet with the chosen offset moved one hop
//   route_dir          0=LOCAL 1=EAST 2=WEST 3=NORTH 4=SOUTH
//   route_valid        route_packet/route_dir hold a packet
//   route_ready        consumer takes the packet on valid&ready at posedge
//   fifo_count         FIFO occupancy after the edge, 0..FIFO_DEPTH
//   overflow           sticky, set when a packet is dropped on a full FIFO
//   drop_count         (DROP_COUNTER_EN only) saturating count of drops
//
// Build option: define DROP_COUNTER_EN to add the drop_count output.

module spike_packet_router #(
    parameter int PACKET_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int DX_MSB       = 29,
    parameter int DX_LSB       = 21,
    parameter int DY_MSB       = 20,
    parameter int DY_LSB       = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PACKET_WIDTH-1:0]       packet_in,
    input  logic                          packet_in_valid,
    output logic [PACKET_WIDTH-1:0]       route_packet,
    output logic [2:0]                    route_dir,
    output logic                          route_valid,
    input  logic                          route_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
`ifdef DROP_COUNTER_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int XW  = DX_MSB - DX_LSB + 1;
    localparam int YW  = DY_MSB - DY_LSB + 1;

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_EAST  = 3'd1;
    localparam logic [2:0] DIR_WEST  = 3'd2;
    localparam logic [2:0] DIR_NORTH = 3'd3;
    localparam logic [2:0] DIR_SOUTH = 3'd4;

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    state_t state, next_state;

    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           count;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    logic [PACKET_WIDTH-1:0] head;
    logic [XW-1:0]           dx;
    logic [YW-1:0]           dy;
    logic                    dx_pos;
    logic                    dx_neg;
    logic                    dy_pos;
    logic                    dy_neg;
    logic [PACKET_WIDTH-1:0] rt_packet;
    logic [2:0]              rt_dir;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    assign push = packet_in_valid && (!fifo_full || pop);
    assign drop = packet_in_valid && fifo_full && !pop;

    // Output stage FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (route_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = S_EMPTY;
                    end
                end
            end
            default: next_state = S_EMPTY;
        endcase
    end

    assign route_valid = (state == S_HOLD);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= packet_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign fifo_count = count;

    // XY routing of the FIFO head; offsets are two's complement, so the
    // sign bit separates the negative case and non-zero-positive is the rest.
    assign head   = mem[rd_ptr];
    assign dx     = head[DX_MSB:DX_LSB];
    assign dy     = head[DY_MSB:DY_LSB];
    assign dx_neg = dx[XW-1];
    assign dx_pos = !dx[XW-1] && (dx != '0);
    assign dy_neg = dy[YW-1];
    assign dy_pos = !dy[YW-1] && (dy != '0);

    always_comb begin
        rt_packet = head;
        rt_dir    = DIR_LOCAL;
        unique case (1'b1)
            dx_pos: begin
                rt_dir                   = DIR_EAST;
                rt_packet[DX_MSB:DX_LSB] = dx - XW'(1);
            end
            dx_neg: begin
                rt_dir                   = DIR_WEST;
                rt_packet[DX_MSB:DX_LSB] = dx + XW'(1);
            end
            (!dx_pos && !dx_neg && dy_pos): begin
                rt_dir                   = DIR_NORTH;
                rt_packet[DY_MSB:DY_LSB] = dy - YW'(1);
            end
            (!dx_pos && !dx_neg && dy_neg): begin
                rt_dir                   = DIR_SOUTH;
                rt_packet[DY_MSB:DY_LSB] = dy + YW'(1);
            end
            default: begin
                rt_dir    = DIR_LOCAL;
                rt_packet = head;
            end
        endcase
    end

    // Output register loads on every pop and otherwise holds steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_packet <= '0;
            route_dir    <= DIR_LOCAL;
        end else if (pop) begin
            route_packet <= rt_packet;
            route_dir    <= rt_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef DROP_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spike_packet_router.sv
// tb_spike_packet_router: directed-vector bench for spike_packet_router.
// Routing table in a loop, then hand-written FIFO/back-pressure/reset cases.

module tb_spike_packet_router;

    logic        clk;
    logic        rst;
    logic [31:0] packet_in;
    logic        packet_in_valid;
    logic [31:0] route_packet;
    logic [2:0]  route_dir;
    logic        route_valid;
    logic        route_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
`ifdef DROP_COUNTER_EN
    logic [15:0] drop_count;
`endif

    int n_cmp;
    int n_bad;

    spike_packet_router dut (
        .clk             (clk),
        .rst             (rst),
        .packet_in       (packet_in),
        .packet_in_valid (packet_in_valid),
        .route_packet    (route_packet),
        .route_dir       (route_dir),
        .route_valid     (route_valid),
        .route_ready     (route_ready),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
`ifdef DROP_COUNTER_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pkt;
        logic [2:0]  exp_dir;
        logic [31:0] exp_pkt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        packet_in       = '0;
        packet_in_valid = 1'b0;
        route_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push(input logic [31:0] p);
        packet_in       = p;
        packet_in_valid = 1'b1;
        step();
        packet_in_valid = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{"local",      32'h0000_0053, 3'd0, 32'h0000_0053};
        vecs[1] = '{"east_p2",    32'h0040_0053, 3'd1, 32'h0020_0053};
        vecs[2] = '{"west_m1",    32'h3FE0_0053, 3'd2, 32'h0000_0053};
        vecs[3] = '{"north_p1",   32'h0000_1053, 3'd3, 32'h0000_0053};
        vecs[4] = '{"south_m1",   32'h001F_F053, 3'd4, 32'h0000_0053};
        vecs[5] = '{"x_first",    32'h0020_1053, 3'd1, 32'h0000_1053};
        vecs[6] = '{"west_m256",  32'h2000_0053, 3'd2, 32'h2020_0053};
        vecs[7] = '{"east_p255",  32'h1FE0_0053, 3'd1, 32'h1FC0_0053};
        vecs[8] = '{"south_m256", 32'h0010_0ABC, 3'd4, 32'h0010_1ABC};
        vecs[9] = '{"local_axon", 32'hC000_0FFF, 3'd0, 32'hC000_0FFF};

        do_reset();
        check("rst_valid",    32'(route_valid),  32'd0);
        check("rst_packet",   route_packet,      32'd0);
        check("rst_dir",      32'(route_dir),    32'd0);
        check("rst_count",    32'(fifo_count),   32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
`ifdef DROP_COUNTER_EN
        check("rst_drops",    32'(drop_count),   32'd0);
`endif

        // Routing table: push, two-edge latency, consume.
        route_ready = 1'b1;
        foreach (vecs[i]) begin
            push(vecs[i].pkt);
            check({vecs[i].name, "_e0_valid"}, 32'(route_valid), 32'd0);
            check({vecs[i].name, "_e0_count"}, 32'(fifo_count),  32'd1);
            step();
            check({vecs[i].name, "_valid"}, 32'(route_valid), 32'd1);
            check({vecs[i].name, "_dir"},   32'(route_dir),   32'(vecs[i].exp_dir));
            check({vecs[i].name, "_pkt"},   route_packet,     vecs[i].exp_pkt);
            check({vecs[i].name, "_count"}, 32'(fifo_count),  32'd0);
            step();
            check({vecs[i].name, "_done"},  32'(route_valid), 32'd0);
        end

        // Back-pressure with overflow: 1 held, 4 buffered, 6th dropped.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push(32'h0020_0000 + 32'(16 * (i + 1)));
        end
        check("bp_count",    32'(fifo_count), 32'd4);
        check("bp_overflow", 32'(overflow),   32'd1);
`ifdef DROP_COUNTER_EN
        check("bp_drops",    32'(drop_count), 32'd1);
`endif
        step();
        step();
        check("bp_hold_valid", 32'(route_valid), 32'd1);
        check("bp_hold_pkt",   route_packet,     32'h10);
        route_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_out%0d_valid", k), 32'(route_valid), 32'd1);
            check($sformatf("bp_out%0d_dir", k),   32'(route_dir),   32'd1);
            check($sformatf("bp_out%0d_pkt", k),   route_packet,
                  32'(16 * (k + 1)));
            step();
        end
        check("bp_drain_valid", 32'(route_valid), 32'd0);
        check("bp_drain_count", 32'(fifo_count),  32'd0);
        check("bp_sticky",      32'(overflow),    32'd1);

        // Full FIFO with simultaneous pop and push.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'h0000_0100 + 32'(i));
        end
        check("fp_full_count", 32'(fifo_count), 32'd4);
        route_ready = 1'b1;
        push(32'h0000_0200);
        check("fp_count",    32'(fifo_count), 32'd4);
        check("fp_overflow", 32'(overflow),   32'd0);
        check("fp_pkt",      route_packet,    32'h0000_0101);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("fp_out%0d_pkt", k), route_packet,
                  (k == 3) ? 32'h0000_0200 : 32'h0000_0102 + 32'(k));
        end
        step();
        check("fp_drain_valid", 32'(route_valid), 32'd0);

        // Asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            push(32'h0000_0300 + 32'(i));
        end
        check("ar_pre_overflow", 32'(overflow),    32'd1);
        check("ar_pre_valid",    32'(route_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid",    32'(route_valid), 32'd0);
        check("ar_count",    32'(fifo_count),  32'd0);
        check("ar_overflow", 32'(overflow),    32'd0);
        check("ar_packet",   route_packet,     32'd0);
        #1;
        rst         = 1'b0;
        route_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("ar_idle%0d_valid", k), 32'(route_valid), 32'd0);
        end
        push(32'h0000_1053);
        step();
        check("ar_new_valid", 32'(route_valid), 32'd1);
        check("ar_new_dir",   32'(route_dir),   32'd3);
        check("ar_new_pkt",   route_packet,     32'h0000_0053);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_packet_router.md
Name: spike_packet_router

Overview:
Consumes the registered spike packets produced by the core's send stage (packet_out / packet_out_valid) and buffers them in a small FIFO. Decodes the signed dx/dy hop offsets and applies dimension-ordered XY routing, X first. Emits one packet per handshake with a direction code and the offset adjusted by one hop, or delivers the packet locally when both offsets are zero.

Parameters:
PACKET_WIDTH, 32, packet width; field positions below are fixed for 32.
FIFO_DEPTH, 4, input FIFO entries; power of two, >=2.
DX_MSB, 29 / DX_LSB, 21, signed 9-bit X hop offset.
DY_MSB, 20 / DY_LSB, 12, signed 9-bit Y hop offset.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
packet_in  in  PACKET_WIDTH  packet from send stage
packet_in_valid  in  1  qualifies packet_in; no back-pressure to send stage
route_packet  out  PACKET_WIDTH  packet with adjusted offset
route_dir  out  3  0=LOCAL 1=EAST 2=WEST 3=NORTH 4=SOUTH
route_valid  out  1  route_packet/route_dir valid
route_ready  in  1  consumer accepts when valid&ready at posedge
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a packet was dropped on full FIFO

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, route_valid=0, route_packet=0, route_dir=0, overflow=0. Reset mid-operation discards all buffered and held packets.
- Push: on posedge, if packet_in_valid=1 and (count<FIFO_DEPTH or a pop happens in the same cycle), write packet_in.
- If packet_in_valid=1, the FIFO is full and there is no pop, drop the packet and set overflow=1 until reset.
- packet_in is ignored when packet_in_valid=0.
- Output stage FSM:
  - EMPTY: route_valid=0. If FIFO non-empty, pop the head, route it into the output register, go to HOLD.
  - HOLD: route_valid=1; outputs are stable while route_ready=0.
  - HOLD with route_ready=1 and FIFO non-empty: pop and load the next packet the same edge, stay in HOLD (back-to-back, one packet per cycle).
  - HOLD with route_ready=1 and FIFO empty: go to EMPTY.
- A packet pushed into an empty FIFO while the FSM is in EMPTY: push at edge E0, route_valid=1 after E1 (2-cycle latency). It is not pushed and popped in the same edge.
- Routing, using dx = packet[29:21] and dy = packet[20:12], both two's complement:
  - dx>0: EAST, dx-1.
  - dx<0: WEST, dx+1.
  - dx=0 and dy>0: NORTH, dy-1.
  - dx=0 and dy<0: SOUTH, dy+1.
  - dx=dy=0: LOCAL, packet unchanged.
- Only the selected field changes. Bits 31:30 and 11:0 (axon, tick) pass through unchanged.
- Offset arithmetic is 9-bit with no wrap possible: -256 -> -255, +255 -> +254.
- fifo_count reflects the post-edge occupancy, range 0..FIFO_DEPTH.

Optional Feature:
DROP_COUNTER_EN
- Defined: adds output drop_count [15:0]. It resets to 0, increments on each dropped packet, and saturates at 16'hFFFF. overflow behaves as above.
- Undefined: no drop_count port; only the sticky overflow flag.

Test Plan:
- Local: push 32'h0000_0053, route_ready=1 -> two edges later route_valid=1, route_dir=0, route_packet=32'h0000_0053.
- East/West: push 32'h0040_0053 (dx=+2) -> dir=1, packet=32'h0020_0053. Push 32'h3FE0_0053 (dx=-1) -> dir=2, packet=32'h0000_0053.
- North/South: push 32'h0000_1053 (dy=+1) -> dir=3, packet=32'h0000_0053. Push 32'h001F_F053 (dy=-1) -> dir=4, packet=32'h0000_0053. Push 32'h0020_1053 (dx=1, dy=1) -> dir=1, packet=32'h0000_1053.
- Back-pressure/overflow: route_ready=0, push 6 packets with FIFO_DEPTH=4 -> the first is held in the output register, the next 4 fill the FIFO (fifo_count=4), the 6th is dropped, overflow=1 (drop_count=1 with DROP_COUNTER_EN). Raise route_ready -> 5 packets emerge in order, one per cycle.
- Full with simultaneous pop: FIFO full, route_ready=1 and packet_in_valid=1 on the same edge -> packet accepted, overflow stays 0, fifo_count stays 4.
- Async reset: assert rst mid-stream between clock edges -> route_valid, fifo_count and overflow go to 0 immediately, without waiting for a clock edge. No packets emerge after release until new pushes.
